// File: rtl/float7_pkg.sv
// float7_pkg
//   Types and constants shared by the 7-bit float decoder and by the
//   encoder bench's reference model.
//   - EXP_W / MAN_W / INT_W : field and integer widths
//   - code_t                : {exp, man} packed code, exponent in the MSBs
//   - state_t               : decoder FSM states
//   - implicit_mant()       : value loaded into the shift accumulator
package float7_pkg;

  localparam int EXP_W  = 3;
  localparam int MAN_W  = 4;
  localparam int INT_W  = 11;
  localparam int CODE_W = EXP_W + MAN_W;

  typedef struct packed {
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } code_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Denormals (exp==0) carry no hidden one; normals get the implicit 1
  // above the mantissa before being shifted left by exp-1.
  function automatic logic [INT_W-1:0] implicit_mant(code_t c);
    if (c.exp == '0) begin
      return INT_W'(c.man);
    end
    return INT_W'({1'b1, c.man});
  endfunction

endpackage

// File: rtl/float7_to_int_decoder_if.sv
// float7_to_int_decoder_if
//   Handshake bundle for the float7 decoder.
//   - in_valid / in_ready / in_code    : code input channel
//   - out_valid / out_ready / out_int  : integer result channel
//   - busy                             : decoder not idle
//   master: the producer/consumer side; slave: the decoder.
interface float7_to_int_decoder_if #(
  parameter int CODE_W = float7_pkg::CODE_W,
  parameter int INT_W  = float7_pkg::INT_W
);

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              out_valid;
  logic              out_ready;
  logic [INT_W-1:0]  out_int;
  logic              busy;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_int, busy
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_int, busy
  );

endinterface

// File: rtl/float7_to_int_decoder.sv
// float7_to_int_decoder
//   Expands a 7-bit {exp, man} float code into an 11-bit unsigned integer
//   using a one-bit-per-cycle left shifter.
//   Ports:
//   - clk : rising-edge clock
//   - rst : asynchronous active-high reset
//   - bus : slave side of float7_to_int_decoder_if (valid/ready in and out,
//           plus busy)
//   One code is in flight at a time: accept in IDLE, shift exp-1 times in
//   SHIFT, present the result in DONE until the consumer takes it.
module float7_to_int_decoder #(
  parameter int EXP_W = float7_pkg::EXP_W,
  parameter int MAN_W = float7_pkg::MAN_W,
  parameter int INT_W = float7_pkg::INT_W
) (
  input logic                    clk,
  input logic                    rst,
  float7_to_int_decoder_if.slave bus
);

  // The integer must hold the hidden one, the mantissa and the largest
  // shift (2^EXP_W - 2) exactly, so no bit can ever be shifted out.
  if (INT_W != MAN_W + 1 + (2**EXP_W - 2)) begin : g_bad_int_w
    $error("float7_to_int_decoder: INT_W must equal MAN_W+1+(2^EXP_W-2)");
  end

  // code_t and implicit_mant() are fixed to the package widths.
  if (EXP_W != float7_pkg::EXP_W || MAN_W != float7_pkg::MAN_W ||
      INT_W != float7_pkg::INT_W) begin : g_bad_pkg_w
    $error("float7_to_int_decoder: parameters must match float7_pkg");
  end

  float7_pkg::state_t state_reg, state_next;
  logic [INT_W-1:0]   acc_reg, acc_next;
  logic [EXP_W-1:0]   cnt_reg, cnt_next;
  logic [INT_W-1:0]   out_int_reg, out_int_next;
  float7_pkg::code_t  code;

  assign code = bus.in_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= float7_pkg::IDLE;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      out_int_reg <= '0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      out_int_reg <= out_int_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    out_int_next = out_int_reg;
    unique case (state_reg)
      float7_pkg::IDLE: begin
        if (bus.in_valid) begin
          acc_next = float7_pkg::implicit_mant(code);
          cnt_next = (code.exp == '0) ? '0 : code.exp - EXP_W'(1);
          if (cnt_next == '0) begin
            state_next   = float7_pkg::DONE;
            out_int_next = acc_next;
          end else begin
            state_next = float7_pkg::SHIFT;
          end
        end
      end
      float7_pkg::SHIFT: begin
        acc_next = acc_reg << 1;
        cnt_next = cnt_reg - EXP_W'(1);
        if (cnt_reg == EXP_W'(1)) begin
          state_next   = float7_pkg::DONE;
          out_int_next = acc_next;
        end
      end
      float7_pkg::DONE: begin
        // out_int_reg is left untouched so the result stays visible
        // after the handshake.
        if (bus.out_ready) begin
          state_next = float7_pkg::IDLE;
        end
      end
      default: begin
        state_next = float7_pkg::IDLE;
      end
    endcase
  end

  // All handshake outputs decode from the state register only, so there is
  // no combinational path from in_valid to in_ready.
  assign bus.in_ready  = (state_reg == float7_pkg::IDLE);
  assign bus.out_valid = (state_reg == float7_pkg::DONE);
  assign bus.out_int   = out_int_reg;
  assign bus.busy      = (state_reg != float7_pkg::IDLE);

  // While shifting, the top bit is still clear: at most the final shift
  // of an exp==7 code reaches it.
  a_no_early_msb: assert property (
    @(posedge clk) disable iff (rst)
    (state_reg == float7_pkg::SHIFT) |-> !acc_reg[INT_W-1]
  );

endmodule

// File: tb/tb_float7_to_int_decoder.sv
// tb_float7_to_int_decoder
//   Directed vectors with hand-computed results, backpressure, reset during
//   SHIFT, and a 128-code round trip against an independent decode formula
//   and encoder model.
module tb_float7_to_int_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  float7_to_int_decoder_if bus ();

  float7_to_int_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_decode(input int c);
    int e;
    int m;
    e = (c >> 4) & 7;
    m = c & 15;
    if (e == 0) return m;
    return (16 + m) << (e - 1);
  endfunction

  function automatic int encode(input int v);
    int p;
    if (v < 16) return v;
    p = 4;
    for (int b = 4; b < 11; b++) if (v[b]) p = b;
    return ((p - 3) << 4) | ((v >> (p - 4)) & 15);
  endfunction

  // Present one code, measure accept-to-out_valid latency, optionally
  // stall the consumer for 'hold' cycles, then complete the handshake.
  task automatic run_code(input logic [6:0] code, input int want_val,
                          input int want_lat, input int hold);
    int   lat;
    logic busy_ok;
    logic stable_ok;
    bus.in_code   = code;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    check_val("in_ready_idle", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    bus.in_code  = 7'($urandom);
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 20) begin
      if (!bus.busy || bus.in_ready) busy_ok = 1'b0;
      step();
      bus.in_code = 7'($urandom);
      lat++;
    end
    check_val("latency", lat, want_lat);
    check_val("busy_during", busy_ok, 1);
    check_val("out_int", bus.out_int, want_val);
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!bus.out_valid || bus.out_int != 11'(want_val) || bus.in_ready ||
          !bus.busy)
        stable_ok = 1'b0;
    end
    if (hold > 0) check_val("hold_stable", stable_ok, 1);
    check_val("in_ready_done", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_val("out_valid_clr", bus.out_valid, 0);
    check_val("in_ready_back", bus.in_ready, 1);
    check_val("out_int_kept", bus.out_int, want_val);
    $display("code 0x%02h -> %0d (expected %0d), latency %0d, hold %0d",
             code, bus.out_int, want_val, lat, hold);
  endtask

  initial begin
    int   got;
    int   n;
    logic done;

    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    check_val("rst_in_ready", bus.in_ready, 1);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_int", bus.out_int, 0);
    check_val("rst_busy", bus.busy, 0);
    rst = 1'b0;
    step();

    // Directed vectors
    run_code(7'h05, 5, 1, 0);
    run_code(7'h49, 200, 4, 0);
    run_code(7'h7F, 1984, 7, 0);
    run_code(7'h10, 16, 1, 0);
    run_code(7'h00, 0, 1, 0);
    run_code(7'h3A, 104, 3, 10);

    // Reset during SHIFT of 0x7F, third cycle after accept
    bus.in_code  = 7'h7F;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    check_val("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check_val("midrst_in_ready", bus.in_ready, 1);
    check_val("midrst_out_valid", bus.out_valid, 0);
    check_val("midrst_busy", bus.busy, 0);
    check_val("midrst_out_int", bus.out_int, 0);
    $display("reset pulse during SHIFT of 0x7f applied");
    step();
    rst = 1'b0;
    step();
    run_code(7'h22, 36, 2, 0);

    // Round trip over every code with random consumer backpressure
    for (int c = 0; c < 128; c++) begin
      bus.in_code  = 7'(c);
      bus.in_valid = 1'b1;
      check_val("rt_in_ready", bus.in_ready, 1);
      step();
      bus.in_valid = 1'b0;
      got  = -1;
      n    = 0;
      done = 1'b0;
      while (!done && n < 60) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        if (bus.out_valid && bus.out_ready) begin
          got  = int'(bus.out_int);
          done = 1'b1;
        end
        step();
        n++;
      end
      bus.out_ready = 1'b0;
      check_val("rt_done", done, 1);
      check_val("rt_value", got, ref_decode(c));
      check_val("rt_encode", encode(got), c);
      $display("round trip code 0x%02h -> %0d (expected %0d)", c, got,
               ref_decode(c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/float7_to_int_decoder.md
Name: float7_to_int_decoder

Overview:
- Sequential inverse of the team's 11-bit-integer-to-7-bit-float encoder. Expands a 7-bit code {exp[2:0], man[3:0]} back to an 11-bit unsigned integer.
- Uses an iterative one-bit-per-cycle left shifter behind valid/ready handshakes on both sides.
- Sits downstream of the encoder in round-trip datapaths and benches, and in any consumer needing linear magnitude.

Parameters:
- EXP_W, 3, exponent field width
- MAN_W, 4, mantissa field width
- INT_W, 11, output integer width; must equal MAN_W+1+(2^EXP_W-2), elaboration error otherwise

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  code presented
- in_ready  out  1  decoder can accept a code
- in_code  in  EXP_W+MAN_W  {exp, man}, exp in MSBs
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_int  out  INT_W  decoded integer
- busy  out  1  state != IDLE

Behaviour:
- Value rule:
  - exp==0: value = man (denormal range 0..15).
  - exp>=1: value = (2^MAN_W + man) << (exp-1).
  - Max code 0x7F gives 31<<6 = 1984. Never overflows INT_W.
- FSM states: IDLE, SHIFT, DONE.
- Reset (async assert, sync deassert handled upstream): state=IDLE, acc=0, cnt=0, in_ready=1, out_valid=0, out_int=0, busy=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, load acc (exp==0 ? man : 2^MAN_W+man) and cnt = (exp==0 ? 0 : exp-1).
  - Next state is DONE if cnt==0, else SHIFT.
- SHIFT:
  - in_ready=0. Each cycle acc<<=1 and cnt-=1.
  - When cnt==1 at the clock edge, next state is DONE.
  - No early exit; all exp-1 shifts always execute.
- DONE:
  - out_valid=1 and out_int=acc, held stable until out_valid&out_ready.
  - On that handshake go to IDLE, clear out_valid; out_int keeps its last value.
  - in_ready=0 in DONE. No overlap, so throughput is one code per (latency+1) cycles minimum.
- Latency: accept edge to out_valid high = 1+max(exp-1,0) cycles. This is 1 cycle for exp 0 and 1, 7 cycles for exp 7.
- in_code is sampled only on the accept edge. Changes to in_code while busy are ignored.
- in_valid while not in_ready is ignored; the producer holds it. No combinational path from in_valid to in_ready.
- out_ready low in DONE: the FSM stalls indefinitely with outputs stable.
- out_ready high outside DONE has no effect.
- Reset mid-SHIFT or in DONE: immediate return to reset values, pending result discarded.
- acc is INT_W wide; shifted-out bits are impossible by construction. Assertion: acc[INT_W-1] never set before the final shift unless exp==7.

Decomposition:
- Package float7_pkg holds:
  - EXP_W, MAN_W, INT_W constants
  - typedef code_t as a packed struct {exp, man}
  - state_t enum {IDLE, SHIFT, DONE}
  - function implicit_mant(code_t) returning the loaded acc value
- This package is shared with the encoder bench's reference model.
- No sub-module. FSM plus shift/count datapath stay in one module (~150 lines).

Test Plan:
- Code 0x05 (exp0, man5) with out_ready=1 -> out_int=5, out_valid exactly 1 cycle after accept, in_ready back to 1 the cycle after.
- Code 0x49 (exp4, man9) -> out_int=200 (25<<3), out_valid 4 cycles after accept, busy high throughout.
- Code 0x7F -> out_int=1984, out_valid 7 cycles after accept. Code 0x10 -> 16 after 1 cycle. Code 0x00 -> 0.
- Backpressure: code 0x3A (exp3, man10 -> 104) with out_ready low 10 cycles -> out_valid and out_int=104 held stable, in_ready=0. Release -> single handshake, then return to IDLE.
- Reset pulse during SHIFT of code 0x7F (cycle 3) -> all outputs at reset values immediately. Next code 0x22 decodes to 36 with no residue.
- Exhaustive round-trip: all 128 codes back-to-back with random out_ready -> each out_int matches the package reference model, and encoder(out_int)==code for every code.
